// File: rtl/demux_1_2_buf.sv
// 1-to-2 demultiplexer with an independent 2-entry FIFO on each output channel.
// Define DEMUX_1_2_BUF_PERF_CNT_EN to add per-channel push counters (cnt0, cnt1).
module demux_1_2_buf #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  input  logic             sel,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1,
  output logic             out1_valid,
  input  logic             out1_ready
`ifdef DEMUX_1_2_BUF_PERF_CNT_EN
  ,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
`endif
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } occ_e;

  occ_e             state_q [2];
  occ_e             state_d [2];
  logic [WIDTH-1:0] head_q  [2];
  logic [WIDTH-1:0] head_d  [2];
  logic [WIDTH-1:0] tail_q  [2];
  logic [WIDTH-1:0] tail_d  [2];

  logic [1:0] sel_oh;
  logic [1:0] out_ready;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] not_empty;

  assign sel_oh    = {sel, ~sel};
  assign out_ready = {out1_ready, out0_ready};

  // No pass-through: a FULL channel refuses a push even while it is being popped.
  assign in_ready = ~reset & (sel ? (state_q[1] != StFull) : (state_q[0] != StFull));

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      not_empty[c] = (state_q[c] != StEmpty);
      push[c]      = in_valid & in_ready & sel_oh[c];
      pop[c]       = not_empty[c] & out_ready[c];
    end
  end

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      state_d[c] = state_q[c];
      head_d[c]  = head_q[c];
      tail_d[c]  = tail_q[c];
      unique case (state_q[c])
        StEmpty: begin
          if (push[c]) begin
            state_d[c] = StOne;
            head_d[c]  = in;
          end
        end
        StOne: begin
          if (push[c] && pop[c]) begin
            head_d[c] = in;
          end else if (push[c]) begin
            state_d[c] = StFull;
            tail_d[c]  = in;
          end else if (pop[c]) begin
            state_d[c] = StEmpty;
          end
        end
        StFull: begin
          if (pop[c]) begin
            state_d[c] = StOne;
            head_d[c]  = tail_q[c];
          end
        end
        default: state_d[c] = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (reset) begin
        state_q[c] <= StEmpty;
        head_q[c]  <= '0;
        tail_q[c]  <= '0;
      end else begin
        state_q[c] <= state_d[c];
        head_q[c]  <= head_d[c];
        tail_q[c]  <= tail_d[c];
      end
    end
  end

  assign out0_valid = not_empty[0];
  assign out1_valid = not_empty[1];
  assign out0       = not_empty[0] ? head_q[0] : '0;
  assign out1       = not_empty[1] ? head_q[1] : '0;

`ifdef DEMUX_1_2_BUF_PERF_CNT_EN
  logic [15:0] cnt_q [2];

  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (reset) begin
        cnt_q[c] <= '0;
      end else if (push[c]) begin
        cnt_q[c] <= cnt_q[c] + 16'd1;
      end
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
`endif

endmodule

// File: doc/demux_1_2_buf.md
DEMUX_1_2_BUF -- requirements
Module: demux_1_2_buf

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset sampled on clk rising edge.
REQ-004 The block SHALL have port in, input, WIDTH, word to route.
REQ-005 The block SHALL have port in_valid, input, 1, in holds a valid word.
REQ-006 The block SHALL have port sel, input, 1, destination select: 0 = channel 0, 1 = channel 1.
REQ-007 The block SHALL have port in_ready, output, 1, the selected channel can accept a word this cycle.
REQ-008 The block SHALL have ports out0 and out1, output, WIDTH, head word of each channel buffer.
REQ-009 The block SHALL have ports out0_valid and out1_valid, output, 1, the matching outN holds a valid word.
REQ-010 The block SHALL have ports out0_ready and out1_ready, input, 1, the downstream consumer takes outN this cycle.

Function
REQ-011 Each channel SHALL own an independent 2-entry FIFO with occupancy state EMPTY (0), ONE (1) or FULL (2).
REQ-012 in_ready SHALL be combinational and equal 1 when the FIFO selected by the current sel is not FULL.
REQ-013 A push SHALL occur to channel sel when in_valid && in_ready; the word goes to that channel only and the other channel is unchanged.
REQ-014 outN_valid SHALL be 1 exactly when channel N is not EMPTY; outN SHALL present the oldest stored word.
REQ-015 A pop SHALL occur on channel N when outN_valid && outN_ready; outN_ready while outN_valid=0 SHALL have no effect.
REQ-016 Latency SHALL be one cycle: a word pushed at edge k is visible on outN with outN_valid=1 immediately after edge k.
REQ-017 Each channel SHALL preserve order; no word SHALL be dropped or duplicated.
REQ-018 State transitions SHALL be: EMPTY+push->ONE; ONE+push->FULL; ONE+pop->EMPTY; ONE+push+pop->ONE (head replaced by new word); FULL+pop->ONE; no event->hold.
REQ-019 In FULL, in_ready SHALL be 0 for that channel even if a pop occurs in the same cycle; no pass-through.
REQ-020 A push to one channel and a pop from the other channel in the same cycle SHALL both complete.
REQ-021 While outN_valid=1 and no pop occurs, outN SHALL hold stable.
REQ-022 When outN_valid=0, outN SHALL be 0.
REQ-023 in and sel SHALL be ignored when in_valid=0.

Reset
REQ-024 When reset=1 at a clk edge, both channels SHALL go EMPTY, out0/out1 SHALL be 0, out0_valid/out1_valid SHALL be 0, and any in-flight push or pop in that cycle SHALL be discarded.
REQ-025 While reset=1, in_ready SHALL be 0.
REQ-026 On the first edge after reset deasserts, the block SHALL accept a push normally.

Configuration
REQ-027 The macro DEMUX_1_2_BUF_PERF_CNT_EN SHALL compile in per-channel transfer counters.
REQ-028 With the macro defined, the block SHALL add output ports cnt0 and cnt1, 16 bits each, counting pushes to channel 0 and 1 respectively.
REQ-029 The counters SHALL reset to 0 on reset, increment by 1 per push, and wrap from 0xFFFF to 0x0000.
REQ-030 Without the macro, the counter ports and logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-031 Reset test: assert reset with both FIFOs FULL -> next cycle out0_valid=out1_valid=0, out0=out1=0, and cnt0=cnt1=0 when counters are enabled.
REQ-032 Routing test: push 0xDEADBEEF with sel=0 then 0x12345678 with sel=1, both outN_ready=0 -> out0=0xDEADBEEF and out1=0x12345678 one cycle after each push, with the other channel unaffected.
REQ-033 Full/backpressure test: push 0x1, 0x2, 0x3 to channel 0 with out0_ready=0 -> in_ready=0 after the second push, 0x3 is held off, and draining yields 0x1 then 0x2.
REQ-034 Simultaneous push/pop test: channel 1 in ONE holding 0xA, push 0xB with out1_ready=1 -> state stays ONE and out1=0xB next cycle.
REQ-035 Cross-channel concurrency test: channel 0 FULL, push to channel 1 while popping channel 0 -> both complete and channel 0 state becomes ONE.
REQ-036 Counter wrap test (macro defined): 65537 pushes to channel 0 -> cnt0=0x0001 and cnt1=0x0000.
